// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V front end.
// Contents: XLEN, the NOP and ECALL encodings, the default reset PC and the
// fetch FSM state type.
package riscv_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
    localparam logic [XLEN-1:0] INST_ECALL       = 32'h0000_0073;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0004;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, the instruction memory, the EX
// redirect path and the decoder.
//   imem_addr / imem_inst    : word address out, instruction back in the same cycle
//   redirect_valid / _pc     : taken branch/jump from EX
//   id_ready                 : decoder accepts the IF/ID contents this cycle
//   if_id_*                  : IF/ID pipeline register contents
// Handshake: IF/ID contents transfer to the decoder on a cycle where
// if_id_valid && id_ready. While if_id_valid && !id_ready the fetch stage
// holds if_id_* stable. id_ready may be asserted with if_id_valid low; it
// has no effect on the decoder side then.
interface fetch_unit_if;
    import riscv_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_inst;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_ready;
    logic            if_id_valid;
    logic [XLEN-1:0] if_id_pc;
    logic [XLEN-1:0] if_id_pc_plus4;
    logic [XLEN-1:0] if_id_inst;

    // Fetch-stage side.
    modport master (
        output imem_addr,
        input  imem_inst,
        input  redirect_valid,
        input  redirect_pc,
        input  id_ready,
        output if_id_valid,
        output if_id_pc,
        output if_id_pc_plus4,
        output if_id_inst
    );

    // Environment side (memory, EX, decoder).
    modport slave (
        input  imem_addr,
        output imem_inst,
        output redirect_valid,
        output redirect_pc,
        output id_ready,
        input  if_id_valid,
        input  if_id_pc,
        input  if_id_pc_plus4,
        input  if_id_inst
    );

endinterface

// File: rtl/fetch_pc_gen.sv
// Program counter register with its next-PC selection.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (pc <= RESET_PC)
//   load        : load load_pc (redirect), highest priority after reset
//   load_pc     : redirect target
//   inc         : step to pc + 4 (wraps modulo 2^32)
//   pc          : current PC
//   pc_plus4    : pc + 4
module fetch_pc_gen
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic            inc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// PC generation plus the IF/ID pipeline register.
// Presents the PC to a combinational instruction memory, captures the returned
// instruction with its PC into IF/ID, honours decoder back-pressure, takes
// redirects from EX and freezes on fetching ECALL until redirected.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   bus (master)    : imem_addr/imem_inst, redirect_valid/redirect_pc,
//                     id_ready, if_id_valid/if_id_pc/if_id_pc_plus4/if_id_inst
//   halted          : stage is in HALT
//   fetch_misalign  : sticky misaligned-redirect flag (FETCH_ALIGN_CHECK_EN only)
//   dbg_state       : FSM state
// Build option FETCH_ALIGN_CHECK_EN: a redirect to a non-word-aligned target
// halts the stage and raises fetch_misalign. Without it the low two target
// bits are dropped.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] HALT_INST = INST_ECALL
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus,
    output logic          halted,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic          fetch_misalign,
`endif
    output fetch_state_t  dbg_state
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_plus4, redirect_target;
    logic            advance, is_halt_inst, redirect_ok, redirect_bad;

    logic            if_valid;
    logic [XLEN-1:0] if_pc, if_pc4, if_inst;

    assign advance      = (state == RUN) && (!if_valid || bus.id_ready);
    assign is_halt_inst = (bus.imem_inst == HALT_INST);

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_bad    = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    assign redirect_target = bus.redirect_pc;
`else
    assign redirect_bad    = 1'b0;
    assign redirect_target = bus.redirect_pc & ~32'h3;
`endif
    assign redirect_ok = bus.redirect_valid && !redirect_bad;

    // Any redirect (good or bad) blocks the increment; ECALL freezes the PC on itself.
    fetch_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (redirect_ok),
        .load_pc  (redirect_target),
        .inc      (advance && !is_halt_inst && !bus.redirect_valid),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.redirect_valid) begin
            state_nxt = redirect_bad ? HALT : RUN;
        end else if (advance && is_halt_inst) begin
            state_nxt = HALT;
        end
    end

    // IF/ID register. A redirect only clears valid; the data is left as is.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_pc4   <= '0;
            if_inst  <= INST_NOP;
        end else if (bus.redirect_valid) begin
            if_valid <= 1'b0;
        end else if (advance) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
            if_pc4   <= pc_plus4;
            if_inst  <= bus.imem_inst;
        end else if ((state == HALT) && bus.id_ready) begin
            // Decoder has taken the ECALL; nothing follows it.
            if_valid <= 1'b0;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n)            fetch_misalign <= 1'b0;
        else if (redirect_bad) fetch_misalign <= 1'b1;
    end
`endif

    assign bus.imem_addr      = pc;
    assign bus.if_id_valid    = if_valid;
    assign bus.if_id_pc       = if_pc;
    assign bus.if_id_pc_plus4 = if_pc4;
    assign bus.if_id_inst     = if_inst;
    assign halted             = (state == HALT);
    assign dbg_state          = state;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
PC-generation and IF/ID pipeline-register stage directly upstream of the instruction memory.
- Drives the word address to the combinational instruction memory each cycle.
- Captures the returned instruction with its PC into the IF/ID register for the decoder.
- Handles decoder back-pressure, branch/jump redirects from EX, and halting on ECALL.

Parameters:
- RESET_PC, 32'h0000_0004: first fetch address after reset (program starts at word 1).
- HALT_INST, 32'h0000_0073: ECALL encoding; fetching it halts the stage.

Ports:
- clk  in  1: rising-edge clock
- rst_n  in  1: synchronous active-low reset
- imem_addr  out  32: byte address to instruction memory; equals the internal PC
- imem_inst  in  32: instruction returned combinationally for imem_addr
- redirect_valid  in  1: EX-stage taken branch/jump this cycle
- redirect_pc  in  32: redirect target byte address
- id_ready  in  1: decoder accepts the IF/ID contents this cycle
- if_id_valid  out  1: IF/ID holds a valid instruction
- if_id_pc  out  32: PC of the IF/ID instruction
- if_id_pc_plus4  out  32: if_id_pc + 4
- if_id_inst  out  32: captured instruction
- halted  out  1: stage is in HALT
- fetch_misalign  out  1: present only with FETCH_ALIGN_CHECK_EN

Behaviour:
- Reset state: single clock; reset is synchronous and active-low. While rst_n=0 at a clk edge:
  - pc=RESET_PC, state=RUN.
  - if_id_valid=0, if_id_pc=0, if_id_pc_plus4=0, if_id_inst=32'h0000_0013 (NOP).
  - halted=0, fetch_misalign=0.
  - Reset mid-operation discards all in-flight state.
- imem_addr = pc, combinational from the register.
- Latency: an instruction appears in IF/ID one cycle after its PC is presented.
- FSM states:
  - RUN: fetching.
  - HALT: fetch frozen; halted=1.
- Definitions: "advance" = state==RUN && (!if_id_valid || id_ready).
- Priority per edge, highest first: reset > redirect > advance > hold.
- Redirect (redirect_valid=1):
  - pc <= redirect_pc; if_id_valid <= 0 (one-bubble flush); IF/ID data is don't-care, held.
  - Accepted in RUN or HALT; a redirect in HALT returns state to RUN.
  - A redirect wins over a simultaneous stall or a simultaneous ECALL fetch.
- Advance, imem_inst != HALT_INST:
  - IF/ID <= {1, pc, pc+4, imem_inst}; pc <= pc+4.
  - pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- Advance, imem_inst == HALT_INST:
  - IF/ID captures the ECALL with valid=1; pc is not incremented; state <= HALT.
- Hold (stall: if_id_valid && !id_ready): pc and IF/ID unchanged.
- HALT without redirect:
  - If id_ready=1, if_id_valid <= 0 (ECALL consumed), otherwise hold.
  - pc frozen.
- imem_inst is don't-care when the stage does not advance.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Port fetch_misalign exists.
  - A redirect with redirect_pc[1:0] != 0 sets sticky fetch_misalign=1, flushes IF/ID and enters HALT, with pc unchanged.
  - fetch_misalign is cleared only by reset.
- Undefined:
  - No port.
  - redirect_pc[1:0] is forced to 0 before loading pc.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN=32, INST_NOP=32'h0000_0013, INST_ECALL=32'h0000_0073, RESET_PC_DEFAULT.
  - fetch_state_t enum {RUN, HALT}.
- One natural sub-module, fetch_pc_gen: PC register plus next-PC mux (redirect / +4 / hold).
- The IF/ID register and FSM stay in fetch_unit.

Test Plan:
- Reset release, memory model words 1-9 loaded:
  - Cycle 0: imem_addr=0x4, if_id_valid=0.
  - Next edge: if_id_inst=0x00100293, if_id_pc=0x4, if_id_pc_plus4=0x8.
  - Then 0x00300313 at pc 0x8.
- id_ready=0 for 3 cycles while holding 0x0062B223 at pc 0xC: IF/ID and imem_addr=0x10 stable; on release the next capture is 0x0062E3B3 at pc 0x10.
- redirect_valid=1, redirect_pc=0x20 while id_ready=0: next cycle if_id_valid=0 and imem_addr=0x20; following cycle if_id_inst=0x405383B3 at pc 0x24 is not yet captured, instead 0x20's instruction is.
- Memory word at 0x28 = 0x00000073:
  - ECALL captured valid, halted=1, imem_addr stays 0x28.
  - After id_ready, if_id_valid=0.
  - A later redirect to 0x4 resumes with halted=0.
- rst_n=0 for one cycle mid-stall with pc=0x1C: next cycle imem_addr=0x4, if_id_valid=0, halted=0.
- With FETCH_ALIGN_CHECK_EN, redirect_pc=0x22: fetch_misalign=1, halted=1, if_id_valid=0; it stays set until reset.
